meteor_game_ctrl: RTL

Game-state sequencer for the meteor shooter. It sits between the debounced GoBoard switches and the meteor/bullet datapath, and decides when play is enabled, when meteors advance, and when a shot is issued. It also tracks score, lives and level from the datapath's hit and landing events. It derives its frame timebase from the VGA vertical sync, so all game pacing is locked to the 60 Hz frame rate.

---
 rtl/meteor_game_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/meteor_game_ctrl.sv
// Game-state sequencer for the meteor shooter: frame-locked step pacing, shot
// rate limiting and score/lives/level bookkeeping driven by datapath events.
module meteor_game_ctrl #(
  parameter int unsigned c_Lives        = 3,
  parameter int unsigned c_BaseFrames   = 16,
  parameter int unsigned c_HitFrames    = 60,
  parameter int unsigned c_FireCooldown = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_VSync,
  input  logic       i_GameStart,
  input  logic       i_Shoot,
  input  logic       i_MeteorHit,
  input  logic       i_MeteorLanded,
  output logic [1:0] o_State,
  output logic       o_PlayEn,
  output logic       o_StepTick,
  output logic       o_FireReq,
  output logic [7:0] o_Score,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Level
);

  localparam int unsigned FW = ($clog2(c_BaseFrames) > 0) ? $clog2(c_BaseFrames) : 1;
  localparam int unsigned HW = ($clog2(c_HitFrames) > 0) ? $clog2(c_HitFrames) : 1;
  localparam int unsigned CW = ($clog2(c_FireCooldown + 1) > 0) ? $clog2(c_FireCooldown + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_HIT  = 2'd2,
    ST_OVER = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    smp_q, smp_d;
  logic [2:0]    dly_q, dly_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic [HW-1:0] hit_cnt_q, hit_cnt_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [7:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic [2:0]    level_q, level_d;
  logic          play_en_q, play_en_d;
  logic          step_q, step_d;
  logic          fire_q, fire_d;

  logic          frame_tick_c;
  logic          start_edge_c;
  logic          shoot_edge_c;
  logic [FW-1:0] step_last_c;

  // Bit order in the edge pipeline: [2] vsync, [1] start, [0] shoot.
  assign frame_tick_c = dly_q[2] & ~smp_q[2];
  assign start_edge_c = smp_q[1] & ~dly_q[1];
  assign shoot_edge_c = smp_q[0] & ~dly_q[0];

  // Step period shrinks by two frames per level.
  assign step_last_c = FW'(c_BaseFrames - 32'd1 - {28'd0, level_q, 1'b0});

  always_comb begin
    state_d     = state_q;
    smp_d       = {i_VSync, i_GameStart, i_Shoot};
    dly_d       = smp_q;
    frame_cnt_d = frame_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    cool_d      = cool_q;
    score_d     = score_q;
    lives_d     = lives_q;
    level_d     = level_q;
    step_d      = 1'b0;
    fire_d      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_edge_c) begin
          state_d     = ST_PLAY;
          lives_d     = 2'(c_Lives);
          score_d     = 8'd0;
          level_d     = 3'd0;
          frame_cnt_d = '0;
          hit_cnt_d   = '0;
          cool_d      = '0;
        end
      end
      ST_PLAY: begin
        if (frame_tick_c) begin
          // >= so a level-up mid-period that overshoots still steps next frame
          if (frame_cnt_q >= step_last_c) begin
            frame_cnt_d = '0;
            step_d      = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
          if (cool_q != '0) begin
            cool_d = cool_q - CW'(1);
          end
        end
        if (shoot_edge_c && (cool_q == '0)) begin
          fire_d = 1'b1;
          cool_d = CW'(c_FireCooldown);
        end
        if (i_MeteorHit && (score_q != 8'hFF)) begin
          score_d = score_q + 8'd1;
          if ((score_d[2:0] == 3'd0) && (level_q != 3'd7)) begin
            level_d = level_q + 3'd1;
          end
        end
        if (i_MeteorLanded) begin
          if (lives_q == 2'd1) begin
            lives_d = 2'd0;
            state_d = ST_OVER;
          end else begin
            lives_d   = lives_q - 2'd1;
            hit_cnt_d = '0;
            state_d   = ST_HIT;
          end
        end
      end
      ST_HIT: begin
        if (frame_tick_c) begin
          if (hit_cnt_q == HW'(c_HitFrames - 1)) begin
            state_d     = ST_PLAY;
            frame_cnt_d = '0;
          end else begin
            hit_cnt_d = hit_cnt_q + HW'(1);
          end
        end
      end
      ST_OVER: begin
        if (start_edge_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    play_en_d = (state_d == ST_PLAY);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      smp_q       <= {i_VSync, i_GameStart, i_Shoot};
      dly_q       <= {i_VSync, i_GameStart, i_Shoot};
      frame_cnt_q <= '0;
      hit_cnt_q   <= '0;
      cool_q      <= '0;
      score_q     <= 8'd0;
      lives_q     <= 2'd0;
      level_q     <= 3'd0;
      play_en_q   <= 1'b0;
      step_q      <= 1'b0;
      fire_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      smp_q       <= smp_d;
      dly_q       <= dly_d;
      frame_cnt_q <= frame_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      cool_q      <= cool_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      play_en_q   <= play_en_d;
      step_q      <= step_d;
      fire_q      <= fire_d;
    end
  end

  assign o_State    = state_q;
  assign o_PlayEn   = play_en_q;
  assign o_StepTick = step_q;
  assign o_FireReq  = fire_q;
  assign o_Score    = score_q;
  assign o_Lives    = lives_q;
  assign o_Level    = level_q;

endmodule
